// File: rtl/program_loader_if.sv
// Bundle between the image source, the loader and the core's programming port.
// The slave modport is the loader's view; master is the image source / core side.
interface program_loader_if #(
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter int CYC_W   = 8
);
    logic               start;
    logic               img_valid;
    logic [INSTR_W-1:0] img_instr;
    logic [DATA_W-1:0]  img_data;
    logic               img_ready;
    logic [INSTR_W-1:0] prog_in;
    logic [DATA_W-1:0]  data_in;
    logic [ADDR_W-1:0]  prog_add;
    logic               prog_clk;
    logic               cpu_reset;
    logic               halt_in;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [CYC_W-1:0]   cycles_used;

    modport slave (
        input  start, img_valid, img_instr, img_data, halt_in,
        output img_ready, prog_in, data_in, prog_add, prog_clk, cpu_reset,
               busy, done, timeout, cycles_used
    );

    modport master (
        output start, img_valid, img_instr, img_data, halt_in,
        input  img_ready, prog_in, data_in, prog_add, prog_clk, cpu_reset,
               busy, done, timeout, cycles_used
    );
endinterface

// File: rtl/program_loader.sv
// Boot/programming controller: streams image words into the core's programming
// port with a one-cycle prog_clk strobe while holding the core in reset, then
// releases reset and supervises the run until halt or watchdog expiry.
module program_loader #(
    parameter int INSTR_W    = 8,
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 32,
    parameter int CYC_W      = 8
) (
    input logic             osc_clock,
    input logic             reset,
    program_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CYC_W-1:0]  LAST_CYCLE = CYC_W'(RUN_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_LIMIT  = CYC_W'(RUN_CYCLES);

    state_t            state;
    logic [ADDR_W-1:0] addr;

    // Load/run sequencer with every output registered.
    // RUN spends its first cycle dropping the last strobe and releasing
    // cpu_reset; run cycles are counted only once the core is out of reset.
    always_ff @(posedge osc_clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            addr            <= '0;
            bus.img_ready   <= 1'b0;
            bus.prog_in     <= '0;
            bus.data_in     <= '0;
            bus.prog_add    <= '0;
            bus.prog_clk    <= 1'b0;
            bus.cpu_reset   <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.cycles_used <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state           <= SETUP;
                        addr            <= '0;
                        bus.img_ready   <= 1'b1;
                        bus.prog_clk    <= 1'b0;
                        bus.cpu_reset   <= 1'b1;
                        bus.busy        <= 1'b1;
                        bus.done        <= 1'b0;
                        bus.timeout     <= 1'b0;
                        bus.cycles_used <= '0;
                    end
                end
                SETUP: begin
                    bus.prog_clk <= 1'b0;
                    if (bus.img_valid && bus.img_ready) begin
                        bus.prog_in   <= bus.img_instr;
                        bus.data_in   <= bus.img_data;
                        bus.prog_add  <= addr;
                        bus.img_ready <= 1'b0;
                        state         <= STROBE;
                    end
                end
                STROBE: begin
                    bus.prog_clk <= 1'b1;
                    if (addr == LAST_ADDR) begin
                        state <= RUN;
                    end else begin
                        addr          <= addr + 1'b1;
                        bus.img_ready <= 1'b1;
                        state         <= SETUP;
                    end
                end
                RUN: begin
                    if (bus.cpu_reset) begin
                        bus.cpu_reset <= 1'b0;
                        bus.prog_clk  <= 1'b0;
                    end else if (bus.halt_in) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end else if (bus.cycles_used == LAST_CYCLE) begin
                        bus.cycles_used <= CYC_LIMIT;
                        bus.done        <= 1'b1;
                        bus.timeout     <= 1'b1;
                        bus.cpu_reset   <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= DONE;
                    end else begin
                        bus.cycles_used <= bus.cycles_used + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the stimulus pushes the expected write
// for every accepted word and the expected end-of-run status; a monitor pops
// and compares on each prog_clk pulse and on each rising edge of done.
module tb_program_loader;
    localparam int INSTR_W    = 8;
    localparam int DATA_W     = 4;
    localparam int ADDR_W     = 4;
    localparam int DEPTH      = 16;
    localparam int RUN_CYCLES = 32;
    localparam int CYC_W      = 8;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] instr;
        logic [3:0] data;
    } wr_t;

    typedef struct packed {
        logic       timeout;
        logic [7:0] cycles;
        logic       cpu_reset;
    } end_t;

    logic osc_clock = 1'b0;
    logic reset;

    program_loader_if #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) bus ();

    program_loader #(
        .INSTR_W(INSTR_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES), .CYC_W(CYC_W)
    ) dut (
        .osc_clock(osc_clock),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 osc_clock = ~osc_clock;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  strobes  = 0;
    bit  prev_done = 1'b0;
    wr_t  wr_q[$];
    end_t end_q[$];

    logic [7:0] instr_a [16] = '{8'h12, 8'h2F, 8'h3A, 8'h45, 8'h5B, 8'h60, 8'h7E, 8'h81,
                                 8'h9C, 8'hA3, 8'hB7, 8'hC0, 8'hD9, 8'hE4, 8'hF1, 8'h0D};
    logic [3:0] data_a  [16] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h0, 4'hF, 4'h7, 4'h1,
                                 4'h9, 4'h6, 4'hE, 4'h2, 4'hB, 4'h4, 4'hD, 4'h8};
    logic [7:0] instr_b [16] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
                                 8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    logic [3:0] data_b  [16] = '{4'hF, 4'h0, 4'hE, 4'h1, 4'hD, 4'h2, 4'hC, 4'h3,
                                 4'hB, 4'h4, 4'hA, 4'h5, 4'h9, 4'h6, 4'h8, 4'h7};

    // Posedge counter used to measure latencies.
    always @(posedge osc_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [29:0] out_vec();
        return {bus.img_ready, bus.prog_in, bus.data_in, bus.prog_add, bus.prog_clk,
                bus.cpu_reset, bus.busy, bus.done, bus.timeout, bus.cycles_used};
    endfunction

    localparam logic [29:0] RST_VEC = {1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    // Monitor: checks each strobe against the write scoreboard and each run end
    // against the status scoreboard.
    always @(negedge osc_clock) begin
        if (reset !== 1'b1) begin
            if (bus.prog_clk === 1'b1) begin
                strobes++;
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: prog_add %0h with no pending word", bus.prog_add);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("prog_add", 32'(bus.prog_add), 32'(e.addr));
                    check("prog_in", 32'(bus.prog_in), 32'(e.instr));
                    check("data_in", 32'(bus.data_in), 32'(e.data));
                end
            end
            if (bus.done === 1'b1 && !prev_done) begin
                if (end_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: cycles_used %0d", bus.cycles_used);
                end else begin
                    end_t x;
                    x = end_q.pop_front();
                    check("end_timeout", 32'(bus.timeout), 32'(x.timeout));
                    check("end_cycles_used", 32'(bus.cycles_used), 32'(x.cycles));
                    check("end_cpu_reset", 32'(bus.cpu_reset), 32'(x.cpu_reset));
                    check("end_busy", 32'(bus.busy), 32'd0);
                end
            end
            prev_done = (bus.done === 1'b1);
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_pulse();
        bus.start = 1'b1;
        @(posedge osc_clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic load_word(input int idx, input logic [7:0] ins, input logic [3:0] dat);
        bit ok;
        ok = 1'b0;
        bus.img_valid = 1'b1;
        bus.img_instr = ins;
        bus.img_data  = dat;
        for (int k = 0; k < 20; k++) begin
            @(negedge osc_clock);
            if (bus.img_ready === 1'b1) begin
                @(posedge osc_clock);
                #1;
                wr_q.push_back('{addr: 4'(idx), instr: ins, data: dat});
                ok = 1'b1;
                break;
            end
        end
        check("word_accepted", 32'(ok), 32'd1);
    endtask

    task automatic load_range(input int first, input int last, input bit use_b);
        for (int i = first; i <= last; i++) begin
            if (use_b) load_word(i, instr_b[i], data_b[i]);
            else       load_word(i, instr_a[i], data_a[i]);
        end
    endtask

    task automatic wait_run();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge osc_clock);
            if (bus.cpu_reset === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("run_entered", 32'(found), 32'd1);
    endtask

    task automatic wait_done(input int bound);
        bit found;
        found = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge osc_clock);
            if (bus.done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("done_reached", 32'(found), 32'd1);
    endtask

    initial begin
        int c0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.img_valid = 1'b0;
        bus.img_instr = '0;
        bus.img_data  = '0;
        bus.halt_in   = 1'b0;

        // Reset held with random inputs: outputs stay at reset values.
        for (int i = 0; i < 4; i++) begin
            @(posedge osc_clock);
            #1;
            bus.start     = 1'($urandom);
            bus.img_valid = 1'($urandom);
            bus.img_instr = 8'($urandom);
            bus.img_data  = 4'($urandom);
            bus.halt_in   = 1'($urandom);
            @(negedge osc_clock);
            check("reset_outputs", 32'(out_vec()), 32'(RST_VEC));
        end
        @(posedge osc_clock);
        #1;
        reset = 1'b0;
        bus.start = 1'b0; bus.img_valid = 1'b0; bus.halt_in = 1'b0;
        @(negedge osc_clock);
        check("idle_outputs", 32'(out_vec()), 32'(RST_VEC));

        // Run 1: gapless load of table A, halt in the 11th run cycle.
        @(posedge osc_clock);
        #1;
        start_pulse();
        check("setup_ready", 32'({bus.img_ready, bus.busy, bus.cpu_reset, bus.done}), 32'b1110);
        load_word(0, instr_a[0], data_a[0]);
        c0 = cyc;
        load_range(1, 15, 1'b0);
        bus.img_valid = 1'b0;
        wait_run();
        check("reset_release_latency", 32'(cyc - c0), 32'd32);
        check("strobes_run1", 32'(strobes), 32'd16);
        check("run_start_cycles", 32'(bus.cycles_used), 32'd0);
        check("run_prog_clk_low", 32'(bus.prog_clk), 32'd0);
        end_q.push_back('{timeout: 1'b0, cycles: 8'd10, cpu_reset: 1'b0});
        repeat (10) @(posedge osc_clock);
        #1;
        bus.halt_in = 1'b1;
        @(posedge osc_clock);
        #1;
        bus.halt_in = 1'b0;
        repeat (3) @(negedge osc_clock);
        check("halt_sticky", 32'({bus.done, bus.timeout, bus.cpu_reset, bus.cycles_used}), 32'({1'b1, 1'b0, 1'b0, 8'd10}));

        // Run 2: backpressure after word 5, start pulse during RUN, watchdog.
        @(posedge osc_clock);
        #1;
        start_pulse();
        check("restart_clear", 32'({bus.done, bus.timeout, bus.cpu_reset, bus.cycles_used, bus.img_ready}),
              32'({1'b0, 1'b0, 1'b1, 8'd0, 1'b1}));
        load_range(0, 5, 1'b1);
        bus.img_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(negedge osc_clock);
            check("gap_prog_add", 32'(bus.prog_add), 32'd5);
        end
        check("gap_no_strobe", 32'(bus.prog_clk), 32'd0);
        @(posedge osc_clock);
        #1;
        load_range(6, 15, 1'b1);
        bus.img_valid = 1'b0;
        wait_run();
        end_q.push_back('{timeout: 1'b1, cycles: 8'd32, cpu_reset: 1'b1});
        @(posedge osc_clock);
        #1;
        start_pulse();
        @(negedge osc_clock);
        check("start_ignored_in_run", 32'({bus.busy, bus.cpu_reset}), 32'b10);
        wait_done(60);
        check("strobes_run2", 32'(strobes), 32'd32);

        // Run 3: reset during STROBE of word 7, then reload from address 0.
        @(posedge osc_clock);
        #1;
        start_pulse();
        load_range(0, 7, 1'b0);
        reset = 1'b1;
        bus.img_valid = 1'b0;
        #1;
        check("midload_reset_outputs", 32'(out_vec()), 32'(RST_VEC));
        wr_q.delete();
        repeat (2) @(posedge osc_clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge osc_clock);
        #1;
        start_pulse();
        load_range(0, 15, 1'b1);
        bus.img_valid = 1'b0;
        wait_run();
        end_q.push_back('{timeout: 1'b0, cycles: 8'd0, cpu_reset: 1'b0});
        bus.halt_in = 1'b1;
        @(posedge osc_clock);
        #1;
        bus.halt_in = 1'b0;
        repeat (3) @(negedge osc_clock);

        check("strobes_total", 32'(strobes), 32'd55);
        check("write_queue_empty", 32'(wr_q.size()), 32'd0);
        check("end_queue_empty", 32'(end_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/program_loader.md
# program_loader

Parametrised boot/programming controller for the 4-bit computer family. It takes a stream of program and data image words, writes each into the core's programming port with a clean `prog_clk` strobe, and holds the core in reset throughout. After the last word it releases reset and supervises the run, ending on a halt indication or a cycle watchdog. It sits between the image source (bench, UART front-end or ROM) and the `computer` core, and replaces hand-written per-bench load loops.

## Interface
Parameters:
- `INSTR_W`, default 8: instruction word width (`prog_in`).
- `DATA_W`, default 4: data word width (`data_in`).
- `ADDR_W`, default 4: programming address width.
- `DEPTH`, default 16: number of words loaded per image, 1..2^ADDR_W.
- `RUN_CYCLES`, default 32: watchdog limit for the run phase, ≥1.
- `CYC_W`, default 8: width of the cycle counter. Must satisfy 2^CYC_W > RUN_CYCLES.

Ports:
- `osc_clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears everything.
- `start` in 1: one-cycle request to begin a load. Honoured only in IDLE or DONE.
- `img_valid` in 1: image word present.
- `img_instr` in INSTR_W: instruction word for the current address.
- `img_data` in DATA_W: data word for the current address.
- `img_ready` out 1: loader accepts a word this cycle.
- `prog_in` out INSTR_W: to core programming port.
- `data_in` out DATA_W: to core data input.
- `prog_add` out ADDR_W: to core programming address.
- `prog_clk` out 1: write strobe to the core; the core captures on its rising edge.
- `cpu_reset` out 1: reset to the core.
- `halt_in` in 1: core halted (HLT executed).
- `busy` out 1: high in SETUP, STROBE and RUN.
- `done` out 1: run finished; sticky until the next `start` or `reset`.
- `timeout` out 1: run ended by the watchdog; sticky like `done`.
- `cycles_used` out CYC_W: number of run cycles consumed.

## Operation
- All outputs are registered. Reset values: `img_ready`=0, `prog_in`=0, `data_in`=0, `prog_add`=0, `prog_clk`=0, `cpu_reset`=1, `busy`=0, `done`=0, `timeout`=0, `cycles_used`=0. The internal address counter resets to 0 and the FSM to IDLE.
- FSM states:
  - IDLE: `cpu_reset`=1, `img_ready`=0. `start` → SETUP; the address counter clears to 0 and `done`/`timeout` clear.
  - SETUP: `img_ready`=1, `prog_clk`=0. On `img_valid`&&`img_ready` the loader registers `img_instr`→`prog_in`, `img_data`→`data_in` and addr→`prog_add`, then goes to STROBE. With no `img_valid` it stays in SETUP and all outputs hold.
  - STROBE: `prog_clk`=1 and `img_ready`=0 for exactly one cycle. If addr==DEPTH-1, go to RUN. Otherwise addr+1 and go to SETUP.
  - RUN: `cpu_reset`=0 and `cycles_used` counts up from 0.
    - `halt_in`=1 → DONE with `done`=1, `timeout`=0, `cpu_reset` held at 0 so the core output stays readable.
    - `cycles_used` reaching RUN_CYCLES → DONE with `done`=1, `timeout`=1, `cpu_reset`=1 to stop a runaway core.
  - DONE: all outputs hold. `start` → SETUP with `cpu_reset`=1, addr=0, `done`/`timeout`/`cycles_used` cleared.
- `start` is ignored in SETUP, STROBE and RUN.
- `halt_in` is ignored outside RUN.
- Asserting `reset` in any state, including mid-load, forces the reset values asynchronously. The image must then be reloaded from address 0.

## Timing
- `start` is sampled at edge E. SETUP (and `img_ready`=1) follows E.
- A word is accepted at edge A.
  - `prog_in`/`data_in`/`prog_add` are valid after A.
  - `prog_clk` rises after A+1, so data is stable one full cycle before the strobe edge.
  - `prog_clk` falls after A+2, and data holds until the next accept.
- Minimum 2 cycles per word. A gapless load takes 2·DEPTH cycles from the first accept to RUN.
- `cpu_reset` falls at the same edge `prog_clk` falls for the last word.
- `cycles_used`=N when `halt_in` is sampled high in the (N+1)th RUN cycle. `done` rises at the next edge.
- On timeout, `cycles_used`=RUN_CYCLES and `done`, `timeout` and `cpu_reset` rise together.

## Test plan
- Reset check: `reset` held, random inputs → every output at its reset value, `cpu_reset`=1.
- Gapless load (defaults): `start`, then `img_valid`=1 continuously with 16 words → exactly 16 `prog_clk` pulses; `prog_add` 0..15 in order; each pulse's `prog_in`/`data_in` match the word; `cpu_reset`=0 32 cycles after the first accept.
- Backpressure: `img_valid` low for 3 cycles after word 5 → no strobe and `prog_add`=5 held during the gap; word 6 is written at `prog_add`=6.
- Halt: during RUN assert `halt_in` in the 11th RUN cycle → `done`=1, `timeout`=0, `cycles_used`=10, `cpu_reset` stays 0.
- Watchdog: `halt_in` never asserted, RUN_CYCLES=32 → after 32 RUN cycles `done`=1, `timeout`=1, `cycles_used`=32, `cpu_reset`=1.
- Mid-load reset and restart: `reset` during the STROBE of word 7 → reset values. A subsequent `start` reloads from `prog_add`=0. A `start` pulsed during RUN has no effect.
